// File: rtl/fetch_pkg.sv
// Shared state encoding, response codes and timeout default for the fetch master.
// Defining FETCH_TIMEOUT_EN adds the ERR state used by the watchdog build.
package fetch_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1023;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;
`endif

  // Counter only ever holds 0 .. limit-1.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles spent in a bus-wait state and flags expiry.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic advance,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!busy || advance) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A handshake in the final allowed cycle wins over expiry.
  assign expired = busy && !advance && (cnt == LAST);

endmodule

// File: rtl/fetch_master.sv
// Single-outstanding instruction fetch master: PC port in, AR/R bus, instruction port out.
// Defining FETCH_TIMEOUT_EN adds a sticky watchdog that parks the block in ERR.
module fetch_master
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        flush,
  output logic        fetch_timeout
);

  // state | meaning
  // IDLE  | pc_ready high, waiting for a fetch address
  // ADDR  | arvalid high, waiting for arready
  // DATA  | rready high, waiting for rvalid
  // HOLD  | inst_valid high, waiting for inst_ready or flush
  // ERR   | watchdog expired, everything parked until reset

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic [31:0] pc_q;
  logic        drop_pending;

  assign araddr = pc_q;

`ifdef FETCH_TIMEOUT_EN
  logic wd_busy;
  logic wd_advance;
  logic wd_expired;
  logic timeout_q;

  assign wd_busy    = (state == ADDR) || (state == DATA);
  assign wd_advance = ((state == ADDR) && arready) || ((state == DATA) && rvalid);

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (wd_busy),
    .advance(wd_advance),
    .expired(wd_expired)
  );

  assign fetch_timeout = timeout_q;
`else
  assign fetch_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc_q         <= '0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_err     <= 1'b0;
      drop_pending <= 1'b0;
      pc_ready     <= 1'b1;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      inst_valid   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      if (wd_expired) begin
        state     <= ERR;
        arvalid   <= 1'b0;
        rready    <= 1'b0;
        timeout_q <= 1'b1;
      end else
`endif
      case (state)
        IDLE: begin
          // flush has nothing to discard here, so a same-cycle request still goes out
          drop_pending <= 1'b0;
          if (pc_valid) begin
            pc_q     <= pc_in;
            pc_ready <= 1'b0;
            arvalid  <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (flush) drop_pending <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (drop_pending || flush) begin
              drop_pending <= 1'b0;
              pc_ready     <= 1'b1;
              state        <= IDLE;
            end else begin
              inst       <= rdata;
              inst_pc    <= pc_q;
              inst_err   <= (rresp == RESP_ERROR);
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            drop_pending <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || inst_ready) begin
            inst_valid   <= 1'b0;
            drop_pending <= 1'b0;
            pc_ready     <= 1'b1;
            state        <= IDLE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        ERR: begin
          pc_ready   <= 1'b0;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
`endif
        default: begin
          pc_ready   <= 1'b1;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_master.sv
// Bench for fetch_master: directed literal scenarios plus randomized traffic checked
// against a transaction-level obligation model every cycle.
module tb_fetch_master;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic        flush;
  logic        fetch_timeout;

  always #5 clk = ~clk;

  fetch_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .flush(flush), .fetch_timeout(fetch_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- responder ----------------
  int          ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err  = RESP_OKAY;
  bit          rand_rsp = 1'b0;

  task automatic respond();
    if (rand_rsp && !arvalid) ar_delay = $urandom_range(0, 3);
    if (rand_rsp && !rready)  r_delay  = $urandom_range(0, 3);
    if (arvalid) begin arready = (ar_wait >= ar_delay); ar_wait++; end
    else begin arready = 1'b0; ar_wait = 0; end
    if (rready) begin rvalid = (r_wait >= r_delay); r_wait++; end
    else begin rvalid = 1'b0; r_wait = 0; end
    if (rand_rsp) begin rdata = $urandom; rresp = 1'($urandom_range(0, 1)); end
    else begin rdata = rsp_data; rresp = rsp_err; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    respond();
  endtask

  // ---------------- obligation model + per-cycle compare ----------------
  bit          mon_en = 1'b1;
  bit          busy_m, ar_owed, r_owed, have_inst, drop_m;
  logic [31:0] cur_pc, exp_inst, exp_pc;
  logic        exp_err;
  int          ar_hs = 0, delivered = 0;

  always @(negedge clk) begin
    if (!rst) begin
      busy_m = 0; ar_owed = 0; r_owed = 0; have_inst = 0; drop_m = 0;
    end else if (mon_en) begin
      chk("m_pc_ready", 32'(pc_ready), 32'(!busy_m));
      chk("m_arvalid", 32'(arvalid), 32'(ar_owed));
      if (ar_owed) chk("m_araddr", araddr, cur_pc);
      chk("m_rready", 32'(rready), 32'(r_owed));
      chk("m_inst_valid", 32'(inst_valid), 32'(have_inst));
      if (have_inst) begin
        chk("m_inst", inst, exp_inst);
        chk("m_inst_pc", inst_pc, exp_pc);
        chk("m_inst_err", 32'(inst_err), 32'(exp_err));
      end
      chk("m_timeout", 32'(fetch_timeout), 32'd0);
      if (!busy_m) begin
        if (pc_valid) begin busy_m = 1; ar_owed = 1; cur_pc = pc_in; drop_m = 0; end
      end else if (ar_owed) begin
        if (flush) drop_m = 1;
        if (arready) begin ar_owed = 0; r_owed = 1; ar_hs++; end
      end else if (r_owed) begin
        if (flush) drop_m = 1;
        if (rvalid) begin
          r_owed = 0;
          if (drop_m) busy_m = 0;
          else begin have_inst = 1; exp_inst = rdata; exp_pc = cur_pc; exp_err = rresp; end
        end
      end else if (have_inst && (flush || inst_ready)) begin
        have_inst = 0; busy_m = 0;
        if (!flush) delivered++;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic start_fetch(input logic [31:0] pc);
    pc_valid = 1'b1; pc_in = pc;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic wait_inst(input string name);
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk(name, 32'(inst_valid), 32'd1);
  endtask

  task automatic retire();
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
  endtask

  int hs0, dl0;
  bit seen_valid;

  initial begin
    pc_valid = 0; pc_in = '0; arready = 0; rdata = '0; rresp = RESP_OKAY;
    rvalid = 0; inst_ready = 0; flush = 0;
    rst = 1'b0;
    #12;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", 32'(inst_err), 32'd0);
    chk("rst_timeout", 32'(fetch_timeout), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    tick();
    chk("rel_pc_ready", 32'(pc_ready), 32'd1);

    // zero-wait fetch: latency 0 -> 3
    rsp_data = 32'h0000_0413; rsp_err = RESP_OKAY; ar_delay = 0; r_delay = 0;
    start_fetch(32'h8000_0000);
    chk("lat_c1_arvalid", 32'(arvalid), 32'd1);
    chk("lat_c1_araddr", araddr, 32'h8000_0000);
    tick();
    chk("lat_c2_rready", 32'(rready), 32'd1);
    chk("lat_c2_arvalid", 32'(arvalid), 32'd0);
    tick();
    chk("lat_c3_inst_valid", 32'(inst_valid), 32'd1);
    chk("lat_c3_inst", inst, 32'h0000_0413);
    chk("lat_c3_inst_pc", inst_pc, 32'h8000_0000);
    chk("lat_c3_inst_err", 32'(inst_err), 32'd0);
    retire();
    chk("lat_c4_inst_valid", 32'(inst_valid), 32'd0);
    chk("lat_c4_pc_ready", 32'(pc_ready), 32'd1);

    // delayed responder, held instruction
    ar_delay = 1; r_delay = 1; rsp_data = 32'h00A0_0093;
    hs0 = ar_hs; dl0 = delivered;
    start_fetch(32'h8000_0010);
    chk("slow_c1_arvalid", 32'(arvalid), 32'd1);
    tick();
    chk("slow_c2_arvalid", 32'(arvalid), 32'd1);
    chk("slow_c2_araddr", araddr, 32'h8000_0010);
    wait_inst("slow_hold_reached");
    for (int i = 0; i < 5; i++) begin
      chk("slow_hold_inst", inst, 32'h00A0_0093);
      chk("slow_hold_pc", inst_pc, 32'h8000_0010);
      tick();
    end
    retire();
    chk("slow_done_valid", 32'(inst_valid), 32'd0);
    chk("slow_one_ar", 32'(ar_hs - hs0), 32'd1);
    chk("slow_one_inst", 32'(delivered - dl0), 32'd1);

    // flush in ADDR: bus completes, response dropped
    ar_delay = 0; r_delay = 0; rsp_data = 32'h1111_1111;
    seen_valid = 0; hs0 = ar_hs;
    start_fetch(32'h8000_0004);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_c2_rready", 32'(rready), 32'd1);
    seen_valid |= inst_valid;
    tick();
    chk("fl_c3_pc_ready", 32'(pc_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin seen_valid |= inst_valid; tick(); end
    chk("fl_never_valid", 32'(seen_valid), 32'd0);
    chk("fl_ar_done", 32'(ar_hs - hs0), 32'd1);

    // error response, then a clean fetch
    rsp_data = 32'hDEAD_BEEF; rsp_err = RESP_ERROR;
    start_fetch(32'h8000_0020);
    wait_inst("err_valid");
    chk("err_inst", inst, 32'hDEAD_BEEF);
    chk("err_flag", 32'(inst_err), 32'd1);
    retire();
    rsp_data = 32'h0000_0013; rsp_err = RESP_OKAY;
    start_fetch(32'h8000_0024);
    wait_inst("err_next_valid");
    chk("err_next_inst", inst, 32'h0000_0013);
    chk("err_next_flag", 32'(inst_err), 32'd0);
    chk("err_next_pc", inst_pc, 32'h8000_0024);
    retire();

    // reset while waiting in DATA
    r_delay = 3;
    start_fetch(32'h8000_0030);
    tick();
    chk("rd_pre_rready", 32'(rready), 32'd1);
    rst = 1'b0; #1;
    chk("rd_rready", 32'(rready), 32'd0);
    chk("rd_arvalid", 32'(arvalid), 32'd0);
    chk("rd_inst_valid", 32'(inst_valid), 32'd0);
    chk("rd_araddr", araddr, 32'd0);
    tick(); tick();
    rst = 1'b1; r_delay = 0; rsp_data = 32'h0040_0513;
    tick();
    start_fetch(32'h8000_0034);
    wait_inst("rd_fresh_valid");
    chk("rd_fresh_inst", inst, 32'h0040_0513);
    chk("rd_fresh_pc", inst_pc, 32'h8000_0034);
    retire();

    // hung AR channel: watchdog build parks in ERR, default build hangs
    mon_en = 0; ar_delay = 1_000_000;
    start_fetch(32'h8000_0040);
`ifdef FETCH_TIMEOUT_EN
    repeat (7) tick();
    chk("wd_c8_timeout", 32'(fetch_timeout), 32'd0);
    chk("wd_c8_arvalid", 32'(arvalid), 32'd1);
    tick();
    chk("wd_c9_timeout", 32'(fetch_timeout), 32'd1);
    chk("wd_c9_arvalid", 32'(arvalid), 32'd0);
    chk("wd_c9_rready", 32'(rready), 32'd0);
    chk("wd_c9_inst_valid", 32'(inst_valid), 32'd0);
    chk("wd_c9_pc_ready", 32'(pc_ready), 32'd0);
    repeat (3) tick();
    chk("wd_sticky", 32'(fetch_timeout), 32'd1);
`else
    repeat (30) tick();
    chk("hang_arvalid", 32'(arvalid), 32'd1);
    chk("hang_pc_ready", 32'(pc_ready), 32'd0);
    chk("hang_timeout", 32'(fetch_timeout), 32'd0);
`endif
    rst = 1'b0; #1;
    chk("hang_rst_timeout", 32'(fetch_timeout), 32'd0);
    chk("hang_rst_arvalid", 32'(arvalid), 32'd0);
    tick();
    rst = 1'b1; ar_delay = 0;
    tick();
    mon_en = 1;

    // randomized traffic
    rand_rsp = 1'b1; dl0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      pc_valid   = ($urandom_range(0, 3) != 0);
      pc_in      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      flush      = ($urandom_range(0, 9) == 0);
      inst_ready = 1'($urandom_range(0, 1));
      tick();
    end
    pc_valid = 0; flush = 0; inst_ready = 1;
    repeat (12) tick();
    chk("rand_traffic_flowed", 32'(delivered - dl0 > 100), 32'd1);
    chk("rand_end_idle", 32'(pc_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_master.md
FETCH_MASTER -- requirements
Module: fetch_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, is the watchdog limit in cycles (used only with FETCH_TIMEOUT_EN).
REQ-002 Clock and reset: clk input 1, single clock; rst input 1, reset, asynchronous, active-low.
REQ-003 Upstream PC port: pc_in input 32, fetch address; pc_valid input 1, request; pc_ready output 1, accept.
REQ-004 AR channel: araddr output 32, read address; arvalid output 1; arready input 1.
REQ-005 R channel: rdata input 32, read data; rresp input 1, 0=OKAY, 1=ERROR; rvalid input 1; rready output 1.
REQ-006 Downstream instruction port: inst output 32, fetched word; inst_pc output 32, address of inst; inst_err output 1, rresp captured with inst; inst_valid output 1; inst_ready input 1.
REQ-007 Control and status: flush input 1, discard the in-flight or held fetch; fetch_timeout output 1, sticky watchdog flag.

Function
REQ-008 The state machine SHALL have states IDLE, ADDR, DATA, HOLD, plus ERR when FETCH_TIMEOUT_EN is defined.
REQ-009 pc_ready SHALL be 1 only in IDLE; pc_valid&&pc_ready SHALL capture pc_in into pc_q and move the state to ADDR.
REQ-010 In ADDR, arvalid SHALL be 1 and araddr SHALL equal pc_q; arvalid SHALL NOT drop before arready is sampled high, even if flush is asserted.
REQ-011 arvalid&&arready SHALL move the state to DATA; in DATA, rready SHALL be 1.
REQ-012 rvalid&&rready SHALL capture rdata into inst and rresp into inst_err, and move the state to HOLD, or to IDLE if a drop is pending.
REQ-013 In HOLD, inst_valid SHALL be 1 and inst, inst_pc and inst_err SHALL be stable; inst_valid&&inst_ready SHALL move the state to IDLE.
REQ-014 Latency: PC accepted at cycle 0 -> arvalid at cycle 1. With arready at cycle 1 and rvalid at cycle 2, inst_valid SHALL be 1 at cycle 3. Minimum throughput is one instruction per 4 cycles.
REQ-015 flush in IDLE SHALL be ignored; pc_valid in the same cycle SHALL still be accepted.
REQ-016 flush in ADDR or DATA SHALL set a drop_pending flag; the bus transaction SHALL complete and its response SHALL be discarded, with a return to IDLE.
REQ-017 flush in HOLD SHALL force IDLE next cycle with inst_valid 0, even if inst_ready is 1 in the same cycle.
REQ-018 drop_pending SHALL clear on entry to IDLE.
REQ-019 rresp=1 SHALL NOT alter sequencing; it SHALL only be reported on inst_err.

Reset
REQ-020 rst low SHALL immediately force IDLE and set pc_q=0, inst=0, inst_pc=0, inst_err=0, drop_pending=0, fetch_timeout=0 and the watchdog count to 0.
REQ-021 Reset outputs: arvalid=0, rready=0, inst_valid=0, pc_ready=1 once rst is released, araddr=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it without a drain; the responder is reset by the same rst.

Configuration
REQ-023 With FETCH_TIMEOUT_EN defined, a counter SHALL count cycles spent in ADDR or DATA, and clear on every state change.
REQ-024 When the counter reaches TIMEOUT_CYCLES, the block SHALL enter ERR: fetch_timeout=1; pc_ready, arvalid, rready and inst_valid all 0; exit only by reset.
REQ-025 Without FETCH_TIMEOUT_EN, there SHALL be no counter and no ERR state, fetch_timeout SHALL be tied to 0, and a hang SHALL persist indefinitely.

Structure
REQ-026 Shared package fetch_pkg SHALL hold the state encoding, the RESP_OKAY/RESP_ERROR constants and the default for TIMEOUT_CYCLES.
REQ-027 One sub-module, fetch_watchdog (counter plus compare, instantiated only under FETCH_TIMEOUT_EN), is natural; the FSM and datapath SHALL stay in fetch_master.

Verification
REQ-028 Zero-wait responder, pc_in=0x8000_0000 at cycle 0, rdata=0x0000_0413 -> inst_valid at cycle 3, inst=0x0000_0413, inst_pc=0x8000_0000, inst_err=0.
REQ-029 Responder with arready delayed 1 cycle and rvalid 1 cycle after rready; inst_ready held 0 for 5 cycles -> arvalid/araddr stable until accepted, inst stable throughout HOLD, exactly one fetch.
REQ-030 flush in the ADDR cycle, pc_in=0x8000_0004 -> AR and R handshakes complete, inst_valid never 1, back in IDLE the cycle after rvalid.
REQ-031 rresp=1 with rdata=0xDEAD_BEEF -> inst_valid with inst=0xDEAD_BEEF, inst_err=1; the next fetch proceeds normally.
REQ-032 FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8, arready tied 0 -> fetch_timeout=1 eight cycles after arvalid rises, all valids/readies 0; rst low clears it.
REQ-033 rst pulled low while in DATA -> rready=0 and the state is IDLE immediately; a fresh fetch after release succeeds.
